seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised sequential shift-add unsigned multiplier with a start/done handshake. Successor to the team's fixed 3-bit combinational multiplier.
- Trades area for latency: one partial product is accumulated per clock, so a WIDTH x WIDTH multiply takes WIDTH cycles.
- Sits in the arithmetic datapath. Driven by a controller that issues a start and waits for done.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  multiplicand; latched when start is accepted.
- b  input  WIDTH  multiplier; latched when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: product holds a new result.
- product  output  2*WIDTH  last completed result.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, product=0, internal accumulator/operand/counter regs=0.
- Reset takes effect immediately, including mid-operation. The in-flight operation is discarded and no done is produced.
- FSM states: IDLE, RUN, FIN.
- IDLE: start=1 at edge T0 latches a->mcand (zero-extended to 2*WIDTH) and b->mplier. It also clears the accumulator, sets count=0, goes to RUN, and sets busy=1.
- RUN, each edge:
  - if mplier[0]=1, accumulator += mcand (2*WIDTH-bit add, no overflow possible);
  - then mcand <<= 1, mplier >>= 1, count += 1.
  - At the edge where count reaches WIDTH-1 (the WIDTH-th RUN edge, T0+WIDTH), write the final sum to product, set done=1, busy=0, and go to FIN.
- Latency: done and new product are visible in the cycle after edge T0+WIDTH, i.e. exactly WIDTH cycles after start is accepted.
- FIN: lasts one cycle; done=1 and busy=0.
  - Next edge: done=0.
  - If start=1 on that edge, a new operation is accepted (back-to-back; throughput one result per WIDTH+1 cycles) and state goes to RUN. Otherwise state goes to IDLE.
- start while busy=1 is ignored. No queueing, no effect on the in-flight operation or operands.
- a/b may change freely after the accept edge.
- product holds its value until overwritten at the next completion. It is not cleared by a new start.
- Zero operands take the full WIDTH cycles; there is no early termination.
- Counter width: clog2(WIDTH)+1 bits; wrap-around is never reached.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN.
- Defined:
  - An extra input port signed_op (1 bit) is added, sampled with start.
  - When signed_op=1, a and b are two's complement. The magnitudes of a and b are latched, the unsigned shift-add runs unchanged, and the result is negated at the FIN write if sign(a) XOR sign(b).
  - Latency is unchanged (WIDTH cycles).
  - Most negative operands are handled: the magnitude is 2^(WIDTH-1), which fits unsigned in WIDTH bits.
  - When signed_op=0, behaviour is identical to the unsigned block.
- Not defined: no signed_op port; unsigned only.

Test Plan:
- WIDTH=8: reset, then start with a=255, b=255 -> done pulses exactly 8 cycles after the accept edge; product=16'hFE01; busy low again with done.
- WIDTH=8: a=0, b=200 and a=13, b=1 -> product=0 then 13, each with the full 8-cycle latency.
- WIDTH=8: hold start=1 continuously with operand pairs (12,11), (7,9) -> products 132 then 63. Second accept occurs in the FIN cycle; done pulses are 9 cycles apart. Operand changes and start while busy do not corrupt results.
- WIDTH=8: start a=100, b=3; assert rst_n=0 at cycle 4 for 1 cycle -> outputs 0 immediately, no done. A fresh start 6*7 -> product=42.
- WIDTH=3: exhaustive 64 pairs vs a*b (e.g. 7*7=49, 5*6=30); each done after 3 cycles.
- SEQ_MUL_SIGNED_EN, WIDTH=8, signed_op=1:
  - -3*5 -> 16'hFFF1
  - -128*-128 -> 16'h4000
  - 127*-128 -> 16'hC080
  - with signed_op=0, 255*255 -> 16'hFE01

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock.
// Ports: clk, rst_n, start, [signed_op if SEQ_MUL_SIGNED_EN], a, b, busy, done, product.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               signed_op,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   product_q;
  logic [PW-1:0]   sum;
  logic [PW-1:0]   result;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic            accept;
  logic            last;

`ifdef SEQ_MUL_SIGNED_EN
  logic            neg_q;
  logic            neg_d;

  // Run the unsigned core on magnitudes; fix the sign on the way out.
  // A most-negative operand maps to 2^(WIDTH-1), still WIDTH bits.
  always_comb begin
    mag_a = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    neg_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  assign result = neg_q ? (~sum + 1'b1) : sum;
`else
  assign mag_a  = a;
  assign mag_b  = b;
  assign result = sum;
`endif

  assign accept = start && (state_q != RUN);
  assign last   = (count_q == CW'(WIDTH - 1));
  assign sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = FIN;
      FIN:     state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else if (accept) begin
      mcand_q  <= {{WIDTH{1'b0}}, mag_a};
      mplier_q <= mag_b;
      acc_q    <= '0;
      count_q  <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end else if (state_q == RUN) begin
      acc_q    <= sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
      if (last) begin
        product_q <= result;
      end
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == FIN);
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=8 and WIDTH=3.
// Expected products and done cycles are queued at issue time.
module tb_seq_multiplier;

  typedef struct {
    logic [15:0] p;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] prod8;
  logic        start3 = 1'b0;
  logic [2:0]  a3 = '0;
  logic [2:0]  b3 = '0;
  logic        busy3;
  logic        done3;
  logic [5:0]  prod3;
`ifdef SEQ_MUL_SIGNED_EN
  logic        sop8 = 1'b0;
  logic        sop3 = 1'b0;
`endif

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q8[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk),
    .rst_n(rst_n),
    .start(start8),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_op(sop8),
`endif
    .a(a8),
    .b(b8),
    .busy(busy8),
    .done(done8),
    .product(prod8)
  );

  seq_multiplier #(.WIDTH(3)) dut3 (
    .clk(clk),
    .rst_n(rst_n),
    .start(start3),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_op(sop3),
`endif
    .a(a3),
    .b(b3),
    .busy(busy3),
    .done(done3),
    .product(prod3)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) @cyc %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL w8_spurious_done: got done, want none @cyc %0d", cyc);
      end else begin
        e = q8.pop_front();
        chk("w8_product", prod8, e.p);
        chk("w8_done_cycle", cyc, e.c);
        chk("w8_busy_with_done", busy8, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done3) begin
      if (q3.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL w3_spurious_done: got done, want none @cyc %0d", cyc);
      end else begin
        e = q3.pop_front();
        chk("w3_product", prod3, e.p);
        chk("w3_done_cycle", cyc, e.c);
      end
    end
  end

  // Drive one WIDTH=8 op at a negedge; accept edge follows, done 8 later.
  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] exp);
    start8 = 1'b1;
    a8 = x;
    b8 = y;
    q8.push_back('{p: exp, c: cyc + 1 + 8});
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~x;
    b8 = ~y;
    chk("w8_busy_after_accept", busy8, 1);
    repeat (8) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_product", prod8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'd255, 8'd255, 16'hFE01);
    op8(8'd0, 8'd200, 16'd0);
    op8(8'd13, 8'd1, 16'd13);

    // Back-to-back with start held high and operands disturbed mid-op.
    start8 = 1'b1;
    a8 = 8'd12;
    b8 = 8'd11;
    q8.push_back('{p: 16'd132, c: cyc + 1 + 8});
    @(negedge clk);
    a8 = 8'd99;
    b8 = 8'd77;
    repeat (8) @(negedge clk);
    a8 = 8'd7;
    b8 = 8'd9;
    q8.push_back('{p: 16'd63, c: cyc + 1 + 8});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'd250;
    b8 = 8'd250;
    repeat (10) @(negedge clk);

    // Reset mid-operation: no done, outputs cleared at once.
    start8 = 1'b1;
    a8 = 8'd100;
    b8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_product", prod8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("postrst_product", prod8, 0);
    op8(8'd6, 8'd7, 16'd42);

`ifdef SEQ_MUL_SIGNED_EN
    sop8 = 1'b1;
    op8(8'hFD, 8'd5, 16'hFFF1);
    op8(8'h80, 8'h80, 16'h4000);
    op8(8'd127, 8'h80, 16'hC080);
    sop8 = 1'b0;
    op8(8'd255, 8'd255, 16'hFE01);
`endif

    // Exhaustive WIDTH=3.
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        start3 = 1'b1;
        a3 = 3'(x);
        b3 = 3'(y);
        q3.push_back('{p: 16'(x * y), c: cyc + 1 + 3});
        @(negedge clk);
        start3 = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
    repeat (6) @(negedge clk);

    if (q8.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL w8_missing_done: got %0d pending, want 0", q8.size());
    end
    if (q3.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL w3_missing_done: got %0d pending, want 0", q3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
